// File: rtl/nand_target_emu_if.sv
// NAND async bus bundle between a controller PHY (master) and the target emulator (slave).
interface nand_target_emu_if;
    logic       v_cen;
    logic       v_cle;
    logic       v_ale;
    logic       v_wen;
    logic       v_ren;
    logic       v_wpn;
    logic [7:0] v_dq_in;
    logic [7:0] v_dq_out;
    logic       v_dq_oe;
    logic       v_rbn;

    modport master (
        output v_cen, v_cle, v_ale, v_wen, v_ren, v_wpn, v_dq_in,
        input  v_dq_out, v_dq_oe, v_rbn
    );

    modport slave (
        input  v_cen, v_cle, v_ale, v_wen, v_ren, v_wpn, v_dq_in,
        output v_dq_out, v_dq_oe, v_rbn
    );
endinterface

// File: rtl/nand_target_emu.sv
// Cycle-sampled NAND flash target (ONFI async subset): decodes CLE/ALE/WE#/RE# on v_clk0,
// holds a small page array and drives DQ and R/B#.
//   state      | meaning
//   IDLE       | waiting for a command
//   ADDR       | collecting address cycles for READ / PROGRAM / READ ID
//   DATA_IN    | PROGRAM data cycles fill the page buffer
//   BUSY       | R/B# low, busy counter running
//   DATA_OUT   | page buffer streamed out on RE#
//   ID_OUT     | ID bytes streamed out on RE#
//   STATUS_OUT | status byte driven; RE# rise returns to the prior state
module nand_target_emu #(
    parameter int          PAGE_BYTES  = 16,
    parameter int          NUM_PAGES   = 4,
    parameter int          BUSY_CYCLES = 64,
    parameter logic [39:0] ID_BYTES    = 40'h00_00_A1_D3_2C
) (
    input  logic               v_clk0,
    input  logic               v_rstn0,
    nand_target_emu_if.slave   bus
);
    localparam int CW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);
    localparam logic [13:0]   SYNC_RST  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_STATUS  = 8'h70;
    localparam logic [7:0] CMD_READ_ID = 8'h90;
    localparam logic [7:0] CMD_READ    = 8'h00;
    localparam logic [7:0] CMD_READ_GO = 8'h30;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_PROG_GO = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA_IN, S_BUSY, S_DATA_OUT, S_ID_OUT, S_STATUS_OUT
    } state_t;

    typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ID} op_t;

    logic [13:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic          cen_s, cle_s, ale_s, wen_s, ren_s, wpn_s;
    logic [7:0]    dq_s;
    logic          wen_prev_q, wen_prev_d, ren_prev_q, ren_prev_d;
    logic          we_rise, re_rise;

    state_t        state_q, state_d, prior_q, prior_d;
    state_t        st_base, prior_base, exit_state;
    op_t           op_q, op_d;
    logic [1:0]    addr_cnt_q, addr_cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] page_q, page_d;
    logic          fail_q, fail_d;
    logic          to_read_q, to_read_d;
    logic [2:0]    id_idx_q, id_idx_d;
    logic [BW-1:0] busy_cnt_q, busy_cnt_d;
    logic          busy_lock;
    logic [7:0]    pagebuf_q [PAGE_BYTES];
    logic [7:0]    pagebuf_d [PAGE_BYTES];
    logic [7:0]    array_q [NUM_PAGES][PAGE_BYTES];
    logic [7:0]    array_d [NUM_PAGES][PAGE_BYTES];
    logic [7:0]    dq_out_q, dq_out_d;
    logic          dq_oe_q, dq_oe_d;
    logic [7:0]    id_byte;

    function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
        return CW'((32'(c) + 32'd1) % PAGE_BYTES);
    endfunction

    always_comb begin
        sync1_d    = {bus.v_cen, bus.v_cle, bus.v_ale, bus.v_wen, bus.v_ren, bus.v_wpn, bus.v_dq_in};
        sync2_d    = sync1_q;
        wen_prev_d = wen_s;
        ren_prev_d = ren_s;
    end

    assign {cen_s, cle_s, ale_s, wen_s, ren_s, wpn_s, dq_s} = sync2_q;

    // A WE# edge in the same sample as an RE# edge wins; the RE# edge is dropped.
    assign we_rise = !cen_s && wen_s && !wen_prev_q;
    assign re_rise = !cen_s && ren_s && !ren_prev_q && !we_rise;

    always_comb begin
        state_d    = state_q;
        prior_d    = prior_q;
        op_d       = op_q;
        addr_cnt_d = addr_cnt_q;
        col_d      = col_q;
        page_d     = page_q;
        fail_d     = fail_q;
        to_read_d  = to_read_q;
        id_idx_d   = id_idx_q;
        busy_cnt_d = busy_cnt_q;
        pagebuf_d  = pagebuf_q;
        array_d    = array_q;
        exit_state = to_read_q ? S_DATA_OUT : S_IDLE;
        st_base    = state_q;
        prior_base = prior_q;

        // The counter keeps running while STATUS_OUT is parked on top of BUSY.
        if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
            if (busy_cnt_q == BW'(1)) begin
                if (state_q == S_BUSY) st_base = exit_state;
                if (prior_q == S_BUSY) prior_base = exit_state;
            end
        end
        state_d   = st_base;
        prior_d   = prior_base;
        busy_lock = (st_base == S_BUSY) || (st_base == S_STATUS_OUT && prior_base == S_BUSY);

        if (we_rise) begin
            if (cle_s && !ale_s) begin
                if (dq_s == CMD_RESET) begin
                    state_d    = S_BUSY;
                    busy_cnt_d = BUSY_LOAD;
                    to_read_d  = 1'b0;
                    fail_d     = 1'b0;
                end else if (dq_s == CMD_STATUS) begin
                    state_d = S_STATUS_OUT;
                    if (st_base != S_STATUS_OUT) prior_d = st_base;
                end else if (!busy_lock) begin
                    case (dq_s)
                        CMD_READ_ID: begin
                            state_d    = S_ADDR;
                            op_d       = OP_ID;
                            addr_cnt_d = 2'd0;
                        end
                        CMD_READ: begin
                            state_d    = S_ADDR;
                            op_d       = OP_READ;
                            addr_cnt_d = 2'd0;
                        end
                        CMD_PROG: begin
                            state_d    = S_ADDR;
                            op_d       = OP_PROG;
                            addr_cnt_d = 2'd0;
                            for (int i = 0; i < PAGE_BYTES; i++) pagebuf_d[i] = 8'hFF;
                        end
                        CMD_READ_GO: begin
                            if (st_base == S_ADDR && op_q == OP_READ && addr_cnt_q == 2'd2) begin
                                for (int i = 0; i < PAGE_BYTES; i++) pagebuf_d[i] = array_q[page_q][i];
                                state_d    = S_BUSY;
                                busy_cnt_d = BUSY_LOAD;
                                to_read_d  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        CMD_PROG_GO: begin
                            if (st_base == S_DATA_IN) begin
                                if (wpn_s) begin
                                    for (int i = 0; i < PAGE_BYTES; i++) array_d[page_q][i] = pagebuf_q[i];
                                    fail_d = 1'b0;
                                end else begin
                                    fail_d = 1'b1;
                                end
                                state_d    = S_BUSY;
                                busy_cnt_d = BUSY_LOAD;
                                to_read_d  = 1'b0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end else if (ale_s && !cle_s) begin
                if (st_base == S_ADDR && op_q == OP_ID) begin
                    state_d  = S_ID_OUT;
                    id_idx_d = 3'd0;
                end else if (st_base == S_ADDR && addr_cnt_q == 2'd0) begin
                    col_d      = CW'(32'(dq_s) % PAGE_BYTES);
                    addr_cnt_d = 2'd1;
                end else if (st_base == S_ADDR && addr_cnt_q == 2'd1) begin
                    page_d     = PW'(32'(dq_s) % NUM_PAGES);
                    addr_cnt_d = 2'd2;
                    if (op_q == OP_PROG) state_d = S_DATA_IN;
                end else begin
                    state_d    = S_IDLE;
                    busy_cnt_d = '0;
                end
            end else if (!cle_s && !ale_s) begin
                if (st_base == S_DATA_IN) begin
                    pagebuf_d[col_q] = dq_s;
                    col_d            = col_inc(col_q);
                end else begin
                    state_d    = S_IDLE;
                    busy_cnt_d = '0;
                end
            end
        end else if (re_rise) begin
            case (st_base)
                S_STATUS_OUT: state_d = prior_base;
                S_DATA_OUT:   col_d   = col_inc(col_q);
                S_ID_OUT:     if (id_idx_q < 3'd5) id_idx_d = id_idx_q + 3'd1;
                default:      ;
            endcase
        end
    end

    assign id_byte = (id_idx_q < 3'd5) ? ID_BYTES[8*id_idx_q +: 8] : 8'h00;

    always_comb begin
        dq_oe_d = !cen_s && !ren_s && (state_q inside {S_DATA_OUT, S_ID_OUT, S_STATUS_OUT});
        case (state_q)
            S_DATA_OUT:   dq_out_d = pagebuf_q[col_q];
            S_ID_OUT:     dq_out_d = id_byte;
            S_STATUS_OUT: dq_out_d = {wpn_s, (busy_cnt_q == '0), 5'b0, fail_q};
            default:      dq_out_d = 8'h00;
        endcase
    end

    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            sync1_q    <= SYNC_RST;
            sync2_q    <= SYNC_RST;
            wen_prev_q <= 1'b1;
            ren_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            prior_q    <= S_IDLE;
            op_q       <= OP_READ;
            addr_cnt_q <= 2'd0;
            col_q      <= '0;
            page_q     <= '0;
            fail_q     <= 1'b0;
            to_read_q  <= 1'b0;
            id_idx_q   <= 3'd0;
            busy_cnt_q <= '0;
            dq_out_q   <= 8'h00;
            dq_oe_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            wen_prev_q <= wen_prev_d;
            ren_prev_q <= ren_prev_d;
            state_q    <= state_d;
            prior_q    <= prior_d;
            op_q       <= op_d;
            addr_cnt_q <= addr_cnt_d;
            col_q      <= col_d;
            page_q     <= page_d;
            fail_q     <= fail_d;
            to_read_q  <= to_read_d;
            id_idx_q   <= id_idx_d;
            busy_cnt_q <= busy_cnt_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    // Storage carries no reset: array contents survive a reset and start undefined.
    always_ff @(posedge v_clk0) begin
        pagebuf_q <= pagebuf_d;
        array_q   <= array_d;
    end

    assign bus.v_dq_out = dq_out_q;
    assign bus.v_dq_oe  = dq_oe_q;
    assign bus.v_rbn    = (busy_cnt_q == '0);
endmodule
